// File: rtl/bp_me_wormhole_packet_deserializer_pkg.sv
// Shared wormhole network definitions: header layout macro, FSM states and
// the header/payload-offset helpers used by both encode and decode endpoints.
`ifndef BP_ME_WORMHOLE_HEADER_MACROS
`define BP_ME_WORMHOLE_HEADER_MACROS
`define DECLARE_BP_ME_WORMHOLE_HEADER_S(x_w, y_w, len_w, name) \
  typedef struct packed { \
    logic [len_w-1:0] len; \
    logic [y_w-1:0]   y; \
    logic [x_w-1:0]   x; \
  } name
`endif

package bp_me_wormhole_packet_deserializer_pkg;

  typedef enum logic [1:0] {
    e_ready,
    e_collect,
    e_output
  } deser_state_e;

  function automatic int unsigned wormhole_header_width(input int unsigned x_w,
                                                        input int unsigned y_w,
                                                        input int unsigned len_w);
    return x_w + y_w + len_w;
  endfunction

  // The payload sits directly above the header in the reassembled packet.
  function automatic int unsigned wormhole_payload_offset(input int unsigned x_w,
                                                          input int unsigned y_w,
                                                          input int unsigned len_w);
    return wormhole_header_width(x_w, y_w, len_w);
  endfunction

endpackage

// File: rtl/bp_me_wormhole_packet_deserializer_flit_collector.sv
// Packet buffer and flit slot counter; slot 0 is the header flit, flits past
// the buffer capacity are dropped while the count still advances to len.
module bp_me_wormhole_flit_collector #(
  parameter int unsigned flit_width_p   = 32,
  parameter int unsigned max_num_flit_p = 4,
  parameter int unsigned len_width_p    = 2
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     hdr_v_i,
  input  logic                                     body_v_i,
  input  logic [len_width_p-1:0]                   len_i,
  input  logic [flit_width_p-1:0]                  flit_i,
  output logic                                     last_o,
  output logic [max_num_flit_p*flit_width_p-1:0]   data_o
);

  logic [len_width_p-1:0]                 cnt_r;
  logic [max_num_flit_p*flit_width_p-1:0] buf_r;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_r <= '0;
      buf_r <= '0;
    end else if (hdr_v_i) begin
      buf_r                    <= '0;
      buf_r[flit_width_p-1:0]  <= flit_i;
      cnt_r                    <= len_width_p'(1);
    end else if (body_v_i) begin
      for (int unsigned k = 1; k < max_num_flit_p; k++) begin
        if (32'(cnt_r) == k) buf_r[k*flit_width_p +: flit_width_p] <= flit_i;
      end
      if (!last_o) cnt_r <= cnt_r + 1'b1;
    end
  end

  assign last_o = (cnt_r == len_i);
  assign data_o = buf_r;

endmodule

// File: rtl/bp_me_wormhole_packet_deserializer.sv
// CCE-side wormhole endpoint: reassembles header-on-LSB flits into one packet,
// strips the x/y/len header and hands the payload out over valid/ready.
module bp_me_wormhole_packet_deserializer
  import bp_me_wormhole_packet_deserializer_pkg::*;
#(
  parameter int unsigned x_cord_width_p  = 4,
  parameter int unsigned y_cord_width_p  = 4,
  parameter int unsigned len_width_p     = 2,
  parameter int unsigned flit_width_p    = 32,
  parameter int unsigned max_num_flit_p  = 4,
  parameter int unsigned payload_width_p = 118
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic [flit_width_p-1:0]    flit_i,
  input  logic                       flit_v_i,
  output logic                       flit_ready_o,
  output logic [payload_width_p-1:0] data_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic                       dest_mismatch_o,
  output logic                       overflow_o
);

  localparam int unsigned hdr_width_lp =
    wormhole_header_width(x_cord_width_p, y_cord_width_p, len_width_p);
  localparam int unsigned offset_lp =
    wormhole_payload_offset(x_cord_width_p, y_cord_width_p, len_width_p);
  localparam int unsigned buf_width_lp = max_num_flit_p * flit_width_p;

  `DECLARE_BP_ME_WORMHOLE_HEADER_S(x_cord_width_p, y_cord_width_p, len_width_p, wormhole_header_s);

  wormhole_header_s       hdr;
  deser_state_e           state_r, state_n;
  logic [len_width_p-1:0] len_r;
  logic                   mismatch_r, overflow_r;
  logic                   hdr_v, body_v, last;
  logic [buf_width_lp-1:0] buf_data;

  assign hdr    = flit_i[hdr_width_lp-1:0];
  assign hdr_v  = flit_v_i & flit_ready_o & (state_r == e_ready);
  assign body_v = flit_v_i & flit_ready_o & (state_r == e_collect);

  bp_me_wormhole_flit_collector #(
    .flit_width_p   (flit_width_p),
    .max_num_flit_p (max_num_flit_p),
    .len_width_p    (len_width_p)
  ) collector (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .hdr_v_i  (hdr_v),
    .body_v_i (body_v),
    .len_i    (len_r),
    .flit_i   (flit_i),
    .last_o   (last),
    .data_o   (buf_data)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= e_ready;
      len_r      <= '0;
      mismatch_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (hdr_v) begin
        len_r      <= hdr.len;
        mismatch_r <= (hdr.x != my_x_i) || (hdr.y != my_y_i);
        if (32'(hdr.len) > max_num_flit_p - 1) overflow_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:   if (hdr_v) state_n = (hdr.len == '0) ? e_output : e_collect;
      e_collect: if (body_v && last) state_n = e_output;
      e_output:  if (ready_i) state_n = e_ready;
      default:   state_n = e_ready;
    endcase
  end

  assign flit_ready_o    = reset_i & (state_r != e_output);
  assign v_o             = (state_r == e_output);
  assign data_o          = buf_data[offset_lp +: payload_width_p];
  assign dest_mismatch_o = mismatch_r;
  assign overflow_o      = overflow_r;

endmodule

// File: tb/tb_bp_me_wormhole_packet_deserializer.sv
// Self-checking bench: a default instance and a 3-flit-capacity instance,
// checked against a packet-level reference model.
module tb_bp_me_wormhole_packet_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  my_x = 4'd2;
  logic [3:0]  my_y = 4'd1;

  logic [31:0]  a_flit = '0;
  logic         a_fv = 1'b0, a_rdy, a_v, a_ready = 1'b0, a_mis, a_ovf;
  logic [117:0] a_data;
  logic [31:0]  b_flit = '0;
  logic         b_fv = 1'b0, b_rdy, b_v, b_ready = 1'b0, b_mis, b_ovf;
  logic [85:0]  b_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_me_wormhole_packet_deserializer dut_a (
    .clk_i(clk), .reset_i(rst_n), .my_x_i(my_x), .my_y_i(my_y),
    .flit_i(a_flit), .flit_v_i(a_fv), .flit_ready_o(a_rdy),
    .data_o(a_data), .v_o(a_v), .ready_i(a_ready),
    .dest_mismatch_o(a_mis), .overflow_o(a_ovf)
  );

  bp_me_wormhole_packet_deserializer #(
    .max_num_flit_p  (3),
    .payload_width_p (86)
  ) dut_b (
    .clk_i(clk), .reset_i(rst_n), .my_x_i(my_x), .my_y_i(my_y),
    .flit_i(b_flit), .flit_v_i(b_fv), .flit_ready_o(b_rdy),
    .data_o(b_data), .v_o(b_v), .ready_i(b_ready),
    .dest_mismatch_o(b_mis), .overflow_o(b_ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: concatenate the flits that fit, drop the 10-bit header.
  function automatic logic [127:0] model_payload(input logic [31:0] fl[$],
                                                 input int maxf, input int pw);
    logic [127:0] b = '0;
    for (int k = 0; k < fl.size() && k < maxf; k++) b[k*32 +: 32] = fl[k];
    b = b >> 10;
    if (pw < 128) b = b & ((128'd1 << pw) - 128'd1);
    return b;
  endfunction

  function automatic logic model_mismatch(input logic [31:0] hdr);
    return (hdr[3:0] != my_x) || (hdr[7:4] != my_y);
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [3:0] x, input logic [3:0] y,
                                         input logic [1:0] len, input logic [21:0] up);
    return {up, len, y, x};
  endfunction

  task automatic send_flit(input bit sel, input logic [31:0] f);
    int n = 0;
    if (sel) begin b_flit = f; b_fv = 1'b1; end
    else     begin a_flit = f; a_fv = 1'b1; end
    while (!(sel ? b_rdy : a_rdy) && n < 100) begin @(negedge clk); n++; end
    chk("flit_accept", 128'(n < 100), 128'd1);
    @(negedge clk);
    a_fv = 1'b0;
    b_fv = 1'b0;
  endtask

  task automatic send_pkt(input bit sel, input logic [31:0] fl[$], input int gap);
    for (int k = 0; k < fl.size(); k++) begin
      send_flit(sel, fl[k]);
      if (k != fl.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic recv(input bit sel, input logic [127:0] ed, input logic em, input int hold);
    int n = 0;
    while (!(sel ? b_v : a_v) && n < 100) begin @(negedge clk); n++; end
    chk("v_wait", 128'(n < 100), 128'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_v",    128'(sel ? b_v : a_v), 128'd1);
      chk("hold_rdy",  128'(sel ? b_rdy : a_rdy), 128'd0);
      chk("hold_data", sel ? 128'(b_data) : 128'(a_data), ed);
      @(negedge clk);
    end
    chk("data", sel ? 128'(b_data) : 128'(a_data), ed);
    chk("mismatch", 128'(sel ? b_mis : a_mis), 128'(em));
    if (sel) b_ready = 1'b1; else a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    b_ready = 1'b0;
    chk("v_drop", 128'(sel ? b_v : a_v), 128'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [1:0]  len;
    logic [3:0]  x, y;

    #2;
    chk("rst_rdy", 128'(a_rdy), 128'd0);
    chk("rst_v",   128'(a_v), 128'd0);
    chk("rst_ovf", 128'(b_ovf), 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 128'(a_rdy), 128'd1);

    // single-flit packet
    send_flit(1'b0, 32'h0000_0412);
    chk("single_latency", 128'(a_v), 128'd1);
    chk("single_data_const", 128'(a_data), 128'h1);
    recv(1'b0, 128'h1, 1'b0, 0);

    // four flits, no gaps; len field lives in bits [9:8]
    q = '{32'h1122_3F12, 32'hAAAA_AAAA, 32'hBBBB_BBBB};
    send_pkt(1'b0, q, 0);
    chk("four_no_early_v", 128'(a_v), 128'd0);
    send_flit(1'b0, 32'hCCCC_CCCC);
    chk("four_latency", 128'(a_v), 128'd1);
    q.push_back(32'hCCCC_CCCC);
    recv(1'b0, model_payload(q, 4, 118), 1'b0, 0);

    // bubbles, 5 cycles of backpressure, then back-to-back header
    q = '{mk_hdr(4'd2, 4'd1, 2'd2, 22'h2A5A5A), 32'h1357_9BDF, 32'h2468_ACE0};
    send_pkt(1'b0, q, 2);
    recv(1'b0, model_payload(q, 4, 118), 1'b0, 5);
    chk("b2b_rdy", 128'(a_rdy), 128'd1);
    q = '{mk_hdr(4'd3, 4'd1, 2'd0, 22'h0F0F0F)};
    send_pkt(1'b0, q, 0);
    chk("b2b_latency", 128'(a_v), 128'd1);
    recv(1'b0, model_payload(q, 4, 118), 1'b1, 0);

    // overflow on the 3-flit instance
    chk("ovf_init", 128'(b_ovf), 128'd0);
    q = '{mk_hdr(4'd2, 4'd1, 2'd3, 22'h155555), 32'hDEAD_BEEF, 32'hCAFE_F00D};
    send_pkt(1'b1, q, 1);
    chk("ovf_no_early_v", 128'(b_v), 128'd0);
    send_flit(1'b1, 32'h1234_5678);
    chk("ovf_latency", 128'(b_v), 128'd1);
    q.push_back(32'h1234_5678);
    recv(1'b1, model_payload(q, 3, 86), 1'b0, 0);
    chk("ovf_set", 128'(b_ovf), 128'd1);
    q = '{mk_hdr(4'd2, 4'd5, 2'd1, 22'h3FFFFF), 32'h0BAD_C0DE};
    send_pkt(1'b1, q, 0);
    recv(1'b1, model_payload(q, 3, 86), 1'b1, 1);
    chk("ovf_sticky", 128'(b_ovf), 128'd1);

    // randomized packets on the default instance
    for (int p = 0; p < 24; p++) begin
      len = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? 4'($urandom) : my_x;
      y = ($urandom_range(0, 3) == 0) ? 4'($urandom) : my_y;
      q = '{mk_hdr(x, y, len, 22'($urandom))};
      for (int k = 0; k < int'(len); k++) q.push_back($urandom);
      send_pkt(1'b0, q, $urandom_range(0, 2));
      recv(1'b0, model_payload(q, 4, 118), model_mismatch(q[0]), $urandom_range(0, 3));
    end

    // mid-packet reset after 2 of 4 flits
    q = '{mk_hdr(4'd7, 4'd1, 2'd3, 22'h000123), 32'h5555_5555};
    send_pkt(1'b0, q, 0);
    chk("pre_rst_mis", 128'(a_mis), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_v",    128'(a_v), 128'd0);
    chk("arst_rdy",  128'(a_rdy), 128'd0);
    chk("arst_mis",  128'(a_mis), 128'd0);
    chk("arst_data", 128'(a_data), 128'd0);
    chk("arst_ovf",  128'(b_ovf), 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{mk_hdr(4'd2, 4'd1, 2'd0, 22'h2BCDEF)};
    send_pkt(1'b0, q, 0);
    chk("post_rst_latency", 128'(a_v), 128'd1);
    recv(1'b0, model_payload(q, 4, 118), 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
